// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between the UART receiver and the bus register logic.
// Read latency 1 cycle; writes to a full FIFO are dropped and flagged sticky.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4,
  localparam int DEPTH     = 2 ** DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_stb,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  input  logic                  i_rd_stb,
  output logic [DATA_BITS-1:0]  o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  input  logic [DEPTH_LOG2:0]   i_threshold,
  output logic                  o_level_irq,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CW-1:0]         count;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  drop;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_ok = i_rd_stb & ~o_empty;
  assign wr_ok = i_wr_stb & (~o_full | rd_ok);
  assign drop  = i_wr_stb & o_full & ~rd_ok;

  assign o_count     = count;
  assign o_empty     = (count == '0);
  assign o_full      = (count == FULL_COUNT);
  assign o_level_irq = (i_threshold != '0) && (count >= i_threshold);

  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_rst) begin
      mem[wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_rd_valid <= rd_ok;
      if (rd_ok) begin
        o_rd_data <= mem[rptr];
        rptr      <= rptr + 1'b1;
      end
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      // A fresh drop beats a clear in the same cycle.
      if (drop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model with a read-data scoreboard.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic [4:0] threshold;
  logic       level_irq;
  logic       overrun;
  logic       clr_overrun;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH_LOG2(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_stb(wr_stb), .i_wr_data(wr_data),
    .i_rd_stb(rd_stb), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_empty(empty), .o_full(full), .o_count(count),
    .i_threshold(threshold), .o_level_irq(level_irq),
    .o_overrun(overrun), .i_clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic [4:0] thr;
    int         e_cnt;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_irq;
  } vec_t;

  vec_t       tbl [15];
  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  logic       m_ovr;
  logic       m_vld;
  logic [7:0] m_dat;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = model_q.size();
    chk("rd_valid", int'(rd_valid), int'(m_vld));
    if (m_vld) m_dat = exp_q.pop_front();
    chk("rd_data", int'(rd_data), int'(m_dat));
    chk("count", int'(count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == 16));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("level_irq", int'(level_irq), int'(threshold != 0 && sz >= int'(threshold)));
  endtask

  // One clock: drive inputs, advance the model, check outputs after the edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                      input logic clr, input logic [4:0] thr);
    logic m_full, rd_ok, wr_ok;
    @(negedge clk);
    wr_stb = wr; wr_data = wd; rd_stb = rd; clr_overrun = clr; threshold = thr;
    m_full = (model_q.size() == 16);
    rd_ok  = rd && (model_q.size() != 0);
    wr_ok  = wr && (!m_full || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    if (wr && m_full && !rd_ok) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_vld = rd_ok;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; wr_stb = 1'b1; wr_data = 8'hEE; rd_stb = 1'b1;
    clr_overrun = 1'b0; threshold = 5'd0;
    model_q.delete(); exp_q.delete();
    m_ovr = 1'b0; m_vld = 1'b0; m_dat = 8'h00;
    repeat (cycles) @(posedge clk);
    #1;
    check_status();
    @(negedge clk);
    rst = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_stb = 1'b0; wr_data = 8'h00; rd_stb = 1'b0;
    clr_overrun = 1'b0; threshold = 5'd0;
    m_ovr = 1'b0; m_vld = 1'b0; m_dat = 8'h00;

    //        wr    wd     rd    clr   thr   cnt vld   dat    irq
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 0, 1'b1, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 0, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 0, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 5'd0, 1, 1'b0, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd4, 2, 1'b0, 8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 5'd4, 3, 1'b0, 8'hA5, 1'b0};
    tbl[7]  = '{1'b1, 8'h44, 1'b0, 1'b0, 5'd4, 4, 1'b0, 8'hA5, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd4, 3, 1'b1, 8'h11, 1'b0};
    tbl[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd0, 4, 1'b0, 8'h11, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 3, 1'b1, 8'h22, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 2, 1'b1, 8'h33, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1, 1'b1, 8'h44, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 0, 1'b1, 8'h55, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 0, 1'b0, 8'h55, 1'b0};

    do_reset(2);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr, tbl[i].thr);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_valid", i), int'(rd_valid), int'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_data", i), int'(rd_data), int'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_irq", i), int'(level_irq), int'(tbl[i].e_irq));
    end

    // Fill, drop one, clear overrun, then full simultaneous read/write.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 5'd0);
    chk("fill_full", int'(full), 1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 5'd0);
    chk("drop_overrun", int'(overrun), 1);
    chk("drop_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b1, 5'd0);
    chk("clr_overrun", int'(overrun), 0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 5'd0);
    chk("full_rw_data", int'(rd_data), 8'h00);
    chk("full_rw_count", int'(count), 16);
    chk("full_rw_overrun", int'(overrun), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
    chk("last_word_55", int'(rd_data), 8'h55);
    chk("drained_empty", int'(empty), 1);

    // Drop coincident with clear: the drop wins.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 5'd0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 5'd0);
    chk("race_overrun", int'(overrun), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 5'd0);
    chk("race_cleared", int'(overrun), 0);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 5'd0);

    // Wrap-around: 40 writes with reads keeping the level small.
    for (int i = 0; i < 40; i++)
      step(1'b1, 8'(8'h80 + i), model_q.size() >= 3, 1'b0, 5'd3);
    while (model_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0, 5'd3);
    chk("wrap_last", int'(rd_data), 8'h80 + 39);
    step(1'b0, 8'h00, 1'b1, 1'b0, 5'd3);

    // Reset during a read cancels it.
    step(1'b1, 8'h3C, 1'b0, 1'b0, 5'd0);
    do_reset(1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
    chk("post_reset_valid", int'(rd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each one-cycle data-ready strobe plus data byte from the receiver into a circular FIFO.
- Presents the bytes to the bus-side register logic through a registered read strobe/valid handshake.
- Provides fill level, full/empty, a level-threshold interrupt and a sticky overrun flag, so the bus can drain bytes in bursts without losing characters.

Parameters:
- DATA_BITS, 8: width of each received word; must match the receiver's data width.
- DEPTH_LOG2, 4: log2 of FIFO depth; the default gives 16 entries; legal range 1..8.
- DEPTH, 2**DEPTH_LOG2: number of storage entries; derived, not overridden.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_wr_stb  input  1  one-cycle write strobe (receiver data-ready pulse).
- i_wr_data  input  DATA_BITS  received word, sampled when i_wr_stb=1.
- i_rd_stb  input  1  read request from bus logic; one word per asserted cycle.
- o_rd_data  output  DATA_BITS  word returned by the most recent accepted read; holds between reads.
- o_rd_valid  output  1  one-cycle pulse, the cycle after an accepted read; o_rd_data is valid in that cycle.
- o_empty  output  1  high when count==0.
- o_full  output  1  high when count==DEPTH.
- o_count  output  DEPTH_LOG2+1  current number of stored words, 0..DEPTH.
- i_threshold  input  DEPTH_LOG2+1  level for the threshold flag.
- o_level_irq  output  1  high when count>=i_threshold and i_threshold!=0.
- o_overrun  output  1  sticky flag: a write was dropped because the FIFO was full.
- i_clr_overrun  input  1  one-cycle clear of o_overrun.

Behaviour:
- Reset, sampled on i_clk while i_rst=1:
  - write pointer, read pointer and count set to 0.
  - o_rd_data=0, o_rd_valid=0, o_overrun=0.
  - Hence o_empty=1, o_full=0, o_level_irq=0.
  - Storage contents are not cleared.
  - Reset overrides all other inputs in the same cycle.
  - A reset during a read cancels that read: no o_rd_valid the following cycle.
- Storage: DEPTH x DATA_BITS array.
  - Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
  - Count is kept as a separate DEPTH_LOG2+1 bit register, not derived from pointer difference.
- Write accept: wr_ok = i_wr_stb & (!o_full | rd_ok).
  - On wr_ok: mem[wptr]<=i_wr_data, wptr<=wptr+1.
- Read accept: rd_ok = i_rd_stb & !o_empty.
  - On rd_ok: o_rd_data<=mem[rptr], rptr<=rptr+1, and o_rd_valid<=1 next cycle.
  - Otherwise o_rd_valid<=0 and o_rd_data holds.
  - Read latency is 1 cycle from strobe to valid.
  - Back-to-back strobes yield one word per cycle.
- Count update:
  - +1 on wr_ok & !rd_ok.
  - -1 on rd_ok & !wr_ok.
  - Unchanged when both or neither occur.
- Simultaneous read and write:
  - When full: both accepted; the read returns the oldest word, the write lands in the freed slot, and count stays DEPTH with no overrun.
  - When empty: the read is ignored (no valid pulse); the write is accepted and count becomes 1. The written word is not bypassed to the output; it is readable on a later strobe.
- i_rd_stb while empty: no effect, o_rd_valid stays 0, pointers unchanged.
- Overrun:
  - A write that is not accepted (i_wr_stb & o_full & !rd_ok) is dropped, with no storage or pointer change.
  - The drop sets o_overrun<=1 on the next edge.
  - i_clr_overrun clears o_overrun, but a new drop in the same cycle wins (flag stays 1).
- Combinational decodes of registered count, with no added latency: o_empty, o_full, o_level_irq.
- Ordering: strict first-in first-out across pointer wrap. No word is duplicated or lost except dropped overrun writes.

Test Plan:
- Reset then idle: assert i_rst 2 cycles -> o_empty=1, o_count=0, o_rd_valid=0, o_overrun=0. Then i_rd_stb=1 -> o_rd_valid remains 0.
- Single byte: write 0xA5, then i_rd_stb one cycle later -> o_rd_valid=1 exactly one cycle after the strobe, o_rd_data=0xA5, o_count 1->0, o_empty returns to 1.
- Fill and overrun (DEPTH=16): write 0x00..0x0F -> o_full=1, o_count=16.
  - Write 0xFF -> dropped, o_overrun=1.
  - Read 16 -> 0x00..0x0F in order, 0xFF never appears.
  - Pulse i_clr_overrun -> o_overrun=0.
- Full simultaneous read/write: with the FIFO full of 0x00..0x0F, assert i_wr_stb (0x55) and i_rd_stb together -> o_rd_data=0x00, o_count stays 16, o_overrun=0. The 16th subsequent read returns 0x55.
- Wrap-around: 40 writes of an incrementing pattern, interleaved with reads keeping the level between 1 and 5 -> all 40 words read in order, pointers wrap twice, no valid pulse while empty.
- Threshold and clear race:
  - i_threshold=4 -> o_level_irq rises the cycle count reaches 4 and falls when count drops to 3.
  - i_threshold=0 -> o_level_irq held 0.
  - Overrun drop coincident with i_clr_overrun -> o_overrun stays 1.
